// File: rtl/icb_sram_loader_if.sv
// ICB command/response bundle for icb_sram_loader; the bus master drives
// commands and rsp_ready, the loader is the slave.
interface icb_sram_loader_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );
  modport slave (
    input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );
endinterface

// File: rtl/icb_sram_loader.sv
// ICB slave that packs 32-bit write pairs into 64-bit SRAM words and reads the output SRAM in halves.
// Optional ICB_BASE_CHECK_EN rejects addresses whose [31:12] differ from BASE_ADDR. rst_n is active-high.
module icb_sram_loader #(
  parameter logic [19:0] BASE_ADDR = 20'h10042,
  parameter int          AW        = 12,
  parameter int          DW        = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  icb_sram_loader_if.slave icb,
  output logic          wsbn_sram_input, wsbn_sram_wq0, wsbn_sram_wq1, wsbn_sram_wk0,
  output logic          wsbn_sram_wk1, wsbn_sram_wv0, wsbn_sram_wv1,
  output logic [AW-1:0] waddr_sram_input, waddr_sram_wq0, waddr_sram_wq1, waddr_sram_wk0,
  output logic [AW-1:0] waddr_sram_wk1, waddr_sram_wv0, waddr_sram_wv1,
  output logic [DW-1:0] wdata_sram_input, wdata_sram_wq0, wdata_sram_wq1, wdata_sram_wk0,
  output logic [DW-1:0] wdata_sram_wk1, wdata_sram_wv0, wdata_sram_wv1,
  output logic          csbn_sram_output,
  output logic [AW-1:0] raddr_sram_output,
  input  logic [DW-1:0] rdata_sram_output,
  output logic [31:0]   CONTROL,
  output logic [31:0]   STATUS
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RDREQ = 2'd1, S_RDWAIT = 2'd2, S_RSP = 2'd3;
  localparam logic [3:0] R_CTRL = 4'd7, R_STAT = 4'd8, R_BAD = 4'd15;

  // Regions 0..6 are input, wq0, wq1, wk0, wk1, wv0, wv1 in offset order.
  function automatic logic [3:0] decode(input logic [11:0] o);
    if      (o < 12'h180) return 4'd0;
    else if (o < 12'h3C0) return 4'd1;
    else if (o < 12'h600) return 4'd2;
    else if (o < 12'h840) return 4'd3;
    else if (o < 12'hA80) return 4'd4;
    else if (o < 12'hCC0) return 4'd5;
    else if (o < 12'hF00) return 4'd6;
    else if (o == 12'hF00) return R_CTRL;
    else if (o == 12'hF04) return R_STAT;
    else return R_BAD;
  endfunction

  function automatic logic [11:0] rgn_base(input logic [3:0] r);
    case (r)
      4'd1:    return 12'h180;
      4'd2:    return 12'h3C0;
      4'd3:    return 12'h600;
      4'd4:    return 12'h840;
      4'd5:    return 12'hA80;
      4'd6:    return 12'hCC0;
      default: return 12'h000;
    endcase
  endfunction

  logic [1:0]    state_q, state_d;
  logic [6:0]    wsbn_q;
  logic [AW-1:0] waddr_q, raddr_q;
  logic [DW-1:0] wdata_q, buf_q;
  logic          csbn_q, half_q, rd_half_q, sticky_q, err_q;
  logic [11:0]   half_off_q, rd_off_q;
  logic [31:0]   lo_q, ctrl_q, rdata_q;

  logic        acc, base_ok, bad, wr_pair, rd_hit, fresh_rd;
  logic [11:0] off;
  logic [3:0]  rgn;

`ifdef ICB_BASE_CHECK_EN
  assign base_ok = (icb.icb_cmd_addr[31:12] == BASE_ADDR);
`else
  logic unused_hi;
  assign unused_hi = ^{icb.icb_cmd_addr[31:12], BASE_ADDR};
  assign base_ok   = 1'b1;
`endif

  always_comb begin
    acc      = icb.icb_cmd_valid && (state_q == S_IDLE);
    off      = icb.icb_cmd_addr[11:0];
    rgn      = decode(off);
    bad      = !base_ok || (rgn == R_BAD);
    wr_pair  = half_q && (off == half_off_q);
    rd_hit   = rd_half_q && (off == rd_off_q);
    fresh_rd = icb.icb_cmd_read && !bad && (rgn == 4'd0) && !rd_hit;
    state_d  = state_q;
    case (state_q)
      S_IDLE:   if (acc) state_d = fresh_rd ? S_RDREQ : S_RSP;
      S_RDREQ:  state_d = S_RDWAIT;
      S_RDWAIT: state_d = S_RSP;
      S_RSP:    if (icb.icb_rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;  wsbn_q <= '1;      waddr_q <= '0;    wdata_q <= '0;
      csbn_q <= 1'b1;     raddr_q <= '0;     buf_q <= '0;      half_q <= 1'b0;
      half_off_q <= '0;   lo_q <= '0;        rd_half_q <= 1'b0; rd_off_q <= '0;
      ctrl_q <= '0;       sticky_q <= 1'b0;  rdata_q <= '0;    err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wsbn_q  <= '1;
      csbn_q  <= 1'b1;
      if (acc) begin
        rdata_q <= '0;
        err_q   <= bad;
        if (bad) begin
          sticky_q <= 1'b1;
        end else if (!icb.icb_cmd_read) begin
          if (rgn < R_CTRL) begin
            if (wr_pair) begin
              wsbn_q[rgn[2:0]] <= 1'b0;
              waddr_q <= AW'(off - rgn_base(rgn));
              wdata_q <= DW'({icb.icb_cmd_wdata, lo_q});
              half_q  <= 1'b0;
            end else begin
              lo_q       <= icb.icb_cmd_wdata;
              half_q     <= 1'b1;
              half_off_q <= off;
            end
          end else if (rgn == R_CTRL) begin
            for (int b = 0; b < 4; b++)
              if (icb.icb_cmd_wmask[b]) ctrl_q[8*b +: 8] <= icb.icb_cmd_wdata[8*b +: 8];
            // bit31 is a clear-sticky strobe, never stored
            ctrl_q[31] <= 1'b0;
            if (icb.icb_cmd_wmask[3] && icb.icb_cmd_wdata[31]) sticky_q <= 1'b0;
          end
        end else if (rgn == 4'd0) begin
          if (rd_hit) begin
            rdata_q   <= buf_q[63:32];
            rd_half_q <= 1'b0;
          end else begin
            csbn_q   <= 1'b0;
            raddr_q  <= AW'(off);
            rd_off_q <= off;
          end
        end else if (rgn == R_CTRL) begin
          rdata_q <= ctrl_q;
        end else if (rgn == R_STAT) begin
          rdata_q <= STATUS;
        end
      end
      if (state_q == S_RDWAIT) begin
        buf_q     <= rdata_sram_output;
        rdata_q   <= rdata_sram_output[31:0];
        rd_half_q <= 1'b1;
      end
    end
  end

  assign icb.icb_cmd_ready = (state_q == S_IDLE);
  assign icb.icb_rsp_valid = (state_q == S_RSP);
  assign icb.icb_rsp_rdata = rdata_q;
  assign icb.icb_rsp_err   = err_q;

  assign CONTROL = ctrl_q;
  assign STATUS  = {29'd0, sticky_q, rd_half_q, half_q};

  assign {wsbn_sram_wv1, wsbn_sram_wv0, wsbn_sram_wk1, wsbn_sram_wk0,
          wsbn_sram_wq1, wsbn_sram_wq0, wsbn_sram_input} = wsbn_q;
  assign waddr_sram_input = waddr_q;  assign wdata_sram_input = wdata_q;
  assign waddr_sram_wq0   = waddr_q;  assign wdata_sram_wq0   = wdata_q;
  assign waddr_sram_wq1   = waddr_q;  assign wdata_sram_wq1   = wdata_q;
  assign waddr_sram_wk0   = waddr_q;  assign wdata_sram_wk0   = wdata_q;
  assign waddr_sram_wk1   = waddr_q;  assign wdata_sram_wk1   = wdata_q;
  assign waddr_sram_wv0   = waddr_q;  assign wdata_sram_wv0   = wdata_q;
  assign waddr_sram_wv1   = waddr_q;  assign wdata_sram_wv1   = wdata_q;
  assign csbn_sram_output  = csbn_q;
  assign raddr_sram_output = raddr_q;
endmodule

// File: tb/tb_icb_sram_loader.sv
// Directed bench for icb_sram_loader: a transaction-level model predicts responses,
// SRAM write/read pulses and STATUS/CONTROL; a per-cycle monitor compares against it.
module tb_icb_sram_loader;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  icb_sram_loader_if bus ();
  logic [6:0]        wsbn;
  logic [6:0][11:0]  waddr;
  logic [6:0][63:0]  wdata;
  logic              csbn;
  logic [11:0]       raddr;
  logic [63:0]       ordata;
  logic [31:0]       CONTROL, STATUS;
  logic [63:0]       omem [4096];

  icb_sram_loader dut (
    .clk(clk), .rst_n(rst), .icb(bus.slave),
    .wsbn_sram_input(wsbn[0]), .wsbn_sram_wq0(wsbn[1]), .wsbn_sram_wq1(wsbn[2]), .wsbn_sram_wk0(wsbn[3]),
    .wsbn_sram_wk1(wsbn[4]), .wsbn_sram_wv0(wsbn[5]), .wsbn_sram_wv1(wsbn[6]),
    .waddr_sram_input(waddr[0]), .waddr_sram_wq0(waddr[1]), .waddr_sram_wq1(waddr[2]), .waddr_sram_wk0(waddr[3]),
    .waddr_sram_wk1(waddr[4]), .waddr_sram_wv0(waddr[5]), .waddr_sram_wv1(waddr[6]),
    .wdata_sram_input(wdata[0]), .wdata_sram_wq0(wdata[1]), .wdata_sram_wq1(wdata[2]), .wdata_sram_wk0(wdata[3]),
    .wdata_sram_wk1(wdata[4]), .wdata_sram_wv0(wdata[5]), .wdata_sram_wv1(wdata[6]),
    .csbn_sram_output(csbn), .raddr_sram_output(raddr), .rdata_sram_output(ordata),
    .CONTROL(CONTROL), .STATUS(STATUS)
  );

  // Output SRAM: registered read one cycle after csbn low
  always @(posedge clk) if (!csbn) ordata <= omem[raddr];

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct { int port; logic [11:0] addr; logic [63:0] data; } wr_t;
  typedef struct {
    bit pend; logic [11:0] poff; logic [31:0] plo;
    bit rdh;  logic [11:0] roff; logic [63:0] rbuf;
    logic [31:0] ctrl; bit sticky;
  } mstate_t;
  mstate_t     m;
  wr_t         exp_wr[$];
  logic [11:0] exp_rd[$];
  int          rlo [7] = '{'h000, 'h180, 'h3C0, 'h600, 'h840, 'hA80, 'hCC0};
  int          rhi [7] = '{'h17F, 'h3BF, 'h5FF, 'h83F, 'hA7F, 'hCBF, 'hEFF};
  int          last_port; logic [11:0] last_waddr; logic [63:0] last_wdata;

  function automatic int region(input logic [11:0] o);
    for (int r = 0; r < 7; r++) if (int'(o) >= rlo[r] && int'(o) <= rhi[r]) return r;
    if (o == 12'hF00) return 7;
    if (o == 12'hF04) return 8;
    return -1;
  endfunction

  function automatic logic [31:0] st(input mstate_t s);
    return {29'd0, s.sticky, s.rdh, s.pend};
  endfunction

  task automatic model(input bit rd, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] mask,
                       output logic [31:0] er, output logic ee, output int elat, inout mstate_t s);
    logic [11:0] o; int r; wr_t w;
    o = addr[11:0]; r = region(o); er = '0; ee = 1'b0; elat = 1;
    if (r < 0) begin
      ee = 1'b1; s.sticky = 1'b1;
    end else if (!rd) begin
      if (r < 7) begin
        if (s.pend && s.poff == o) begin
          w.port = r; w.addr = 12'(int'(o) - rlo[r]); w.data = {wd, s.plo};
          exp_wr.push_back(w); s.pend = 1'b0;
        end else begin
          s.pend = 1'b1; s.poff = o; s.plo = wd;
        end
      end else if (r == 7) begin
        for (int b = 0; b < 4; b++) if (mask[b]) s.ctrl[8*b +: 8] = wd[8*b +: 8];
        s.ctrl[31] = 1'b0;
        if (mask[3] && wd[31]) s.sticky = 1'b0;
      end
    end else begin
      if (r == 0) begin
        if (s.rdh && s.roff == o) begin
          er = s.rbuf[63:32]; s.rdh = 1'b0;
        end else begin
          exp_rd.push_back(o); s.rbuf = omem[o]; er = s.rbuf[31:0];
          s.rdh = 1'b1; s.roff = o; elat = 3;
        end
      end else if (r == 7) er = s.ctrl;
      else if (r == 8) er = st(s);
    end
  endtask

  // ---------------- per-cycle monitor ----------------
  always @(negedge clk) if (!rst) begin
    for (int p = 0; p < 7; p++) if (!wsbn[p]) begin
      last_port = p; last_waddr = waddr[p]; last_wdata = wdata[p];
      if (exp_wr.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_write: port %0d addr %h, none expected", p, waddr[p]);
      end else begin
        wr_t e; e = exp_wr.pop_front();
        chk("wr_port", 64'(p), 64'(e.port));
        chk("wr_addr", 64'(waddr[p]), 64'(e.addr));
        chk("wr_data", wdata[p], e.data);
      end
    end
    if (!csbn) begin
      if (exp_rd.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_read: raddr %h, none expected", raddr);
      end else chk("rd_addr", 64'(raddr), 64'(exp_rd.pop_front()));
    end
    if (bus.icb_cmd_ready) begin
      chk("status", 64'(STATUS), 64'(st(m)));
      chk("control", 64'(CONTROL), 64'(m.ctrl));
    end
  end

  // ---------------- driver ----------------
  task automatic op(input bit rd, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] mask,
                    input int hold, output logic [31:0] rdat, output logic rerr);
    mstate_t n; logic [31:0] er; logic ee; int elat, lat, k;
    n = m;
    model(rd, addr, wd, mask, er, ee, elat, n);
    @(negedge clk);
    bus.icb_cmd_valid = 1'b1; bus.icb_cmd_read = rd; bus.icb_cmd_addr = addr;
    bus.icb_cmd_wdata = wd;   bus.icb_cmd_wmask = mask; bus.icb_rsp_ready = (hold == 0);
    k = 0;
    while (!bus.icb_cmd_ready && k < 20) begin @(negedge clk); k++; end
    if (!bus.icb_cmd_ready) begin
      errors++; checks++; $display("FAIL cmd_ready_timeout: addr %h not accepted", addr);
    end
    @(posedge clk); #1 bus.icb_cmd_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.icb_rsp_valid && lat < 20);
    rdat = bus.icb_rsp_rdata; rerr = bus.icb_rsp_err;
    chk("rsp_valid", 64'(bus.icb_rsp_valid), 64'd1);
    chk("rsp_latency", 64'(lat), 64'(elat));
    chk("rsp_rdata", 64'(rdat), 64'(er));
    chk("rsp_err", 64'(rerr), 64'(ee));
    m = n;
    for (int h = 0; h < hold; h++) begin
      chk("hold_cmd_ready", 64'(bus.icb_cmd_ready), 64'd0);
      @(negedge clk);
      chk("hold_rsp_valid", 64'(bus.icb_rsp_valid), 64'd1);
      chk("hold_rdata", 64'(bus.icb_rsp_rdata), 64'(rdat));
      chk("hold_err", 64'(bus.icb_rsp_err), 64'(rerr));
    end
    bus.icb_rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [31:0] rv; logic re;
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] mk = 4'hF);
    op(1'b0, a, d, mk, 0, rv, re);
  endtask
  task automatic rdx(input logic [31:0] a);
    op(1'b1, a, 32'd0, 4'h0, 0, rv, re);
  endtask

  localparam logic [31:0] B = 32'h1004_2000;
  logic [31:0] pr_a [5] = '{32'h1111, 32'h10001111, 32'h22222222, 32'hDEADBEEF, 32'hFFFFFFFF};
  logic [31:0] pr_b [5] = '{32'h11111111, 32'h1111, 32'h33333333, 32'h0BADF00D, 32'h00000000};
  logic [11:0] bnd  [7] = '{12'h17F, 12'h180, 12'h3BF, 12'h3C0, 12'h840, 12'hA80, 12'hEFF};

  initial begin
    for (int i = 0; i < 4096; i++) omem[i] = {32'hA000_0000 | 32'(i), 32'h5000_0000 | 32'(i)};
    omem[5] = 64'h12345678_9ABCDEF0;
    ordata = '0;
    bus.icb_cmd_valid = 1'b0; bus.icb_cmd_read = 1'b0; bus.icb_cmd_addr = '0;
    bus.icb_cmd_wdata = '0;   bus.icb_cmd_wmask = '0;  bus.icb_rsp_ready = 1'b1;
    m = '{default: '0};
    repeat (2) @(negedge clk);
    chk("rst_wsbn", 64'(wsbn), 64'h7F);
    chk("rst_csbn", 64'(csbn), 64'd1);
    chk("rst_waddr_wdata", 64'(waddr[3]) | wdata[6], 64'd0);
    chk("rst_raddr", 64'(raddr), 64'd0);
    chk("rst_control", 64'(CONTROL), 64'd0);
    chk("rst_status", 64'(STATUS), 64'd0);
    chk("rst_cmd_ready", 64'(bus.icb_cmd_ready), 64'd1);
    chk("rst_rsp", {bus.icb_rsp_valid, bus.icb_rsp_err, bus.icb_rsp_rdata}, 64'd0);
    rst = 1'b0;

    // pair into INPUT at offset 0
    wr(B, 32'h11000011);
    chk("t1_status_pend", 64'(STATUS), 64'd1);
    wr(B, 32'h00001111);
    chk("t1_status_clr", 64'(STATUS), 64'd0);
    chk("t1_port", 64'(last_port), 64'd0);
    chk("t1_waddr", 64'(last_waddr), 64'd0);
    chk("t1_wdata", last_wdata, 64'h00001111_11000011);

    // five WK0 pairs
    for (int k = 0; k < 5; k++) begin
      wr(B + 32'h600 + 32'(k), pr_a[k]);
      wr(B + 32'h600 + 32'(k), pr_b[k]);
    end
    chk("t2_port", 64'(last_port), 64'd3);
    chk("t2_waddr", 64'(last_waddr), 64'd4);
    chk("t2_wdata", last_wdata, 64'h00000000_FFFFFFFF);

    // changed offset discards the old half
    wr(B + 32'h600, 32'hAAAA); wr(B + 32'h601, 32'hBBBB); wr(B + 32'h601, 32'hCCCC);
    chk("t3_waddr", 64'(last_waddr), 64'd1);
    chk("t3_wdata", last_wdata, 64'h0000CCCC_0000BBBB);

    // region boundaries
    for (int k = 0; k < 7; k++) begin
      wr(B + 32'(bnd[k]), 32'h0100_0000 + 32'(k)); wr(B + 32'(bnd[k]), 32'h0200_0000 + 32'(k));
    end
    chk("t4_wv1_port", 64'(last_port), 64'd6);
    chk("t4_wv1_waddr", 64'(last_waddr), 64'h23F);

    // output SRAM read in two halves, then restart on a different offset
    rdx(B + 32'h005); chk("t5_lo", 64'(rv), 64'h9ABCDEF0);
    rdx(B + 32'h005); chk("t5_hi", 64'(rv), 64'h12345678);
    rdx(B + 32'h005); rdx(B + 32'h006); rdx(B + 32'h006);
    rdx(B + 32'h200); chk("t5_wq_zero", 64'(rv), 64'd0);

    // CONTROL masking, pairing survives a CONTROL write
    wr(B + 32'hF00, 32'h000000FF, 4'b0001);
    rdx(B + 32'hF00); chk("t6_ctrl", 64'(rv), 64'hFF);
    wr(B + 32'h050, 32'h1234); wr(B + 32'hF00, 32'hA5A5A5A5, 4'b0100); wr(B + 32'h050, 32'h5678);
    chk("t6_pair_kept", last_wdata, 64'h00005678_00001234);
    wr(B + 32'hF04, 32'hFFFFFFFF);
    rdx(B + 32'hF04);

    // bad offsets and sticky clear
    rdx(B + 32'hF08); chk("t7_err", 64'(re), 64'd1); chk("t7_sticky", 64'(STATUS[2]), 64'd1);
    wr(B + 32'hFFC, 32'h1);
    wr(B + 32'hF00, 32'h80000000, 4'b1000);
    chk("t7_sticky_clr", 64'(STATUS[2]), 64'd0);
    chk("t7_ctrl_after", 64'(CONTROL), 64'h00A500FF);

    // response back-pressure, then reset mid-pair
    op(1'b0, B + 32'h010, 32'hDEAD0001, 4'hF, 3, rv, re);
    @(negedge clk); rst = 1'b1; m = '{default: '0};
    @(negedge clk);
    chk("t8_rst_status", 64'(STATUS), 64'd0);
    chk("t8_rst_control", 64'(CONTROL), 64'd0);
    rst = 1'b0;
    wr(B + 32'h010, 32'hBEEF0002);
    chk("t8_low_again", 64'(STATUS), 64'd1);
    wr(B + 32'h010, 32'hBEEF0003);
    chk("t8_wdata", last_wdata, 64'hBEEF0003_BEEF0002);

    repeat (3) @(negedge clk);
    chk("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
    chk("exp_rd_drained", 64'(exp_rd.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
